issue_ctrl: RTL and testbench

- Sequences the decode-to-execute boundary of the RV64 core. Sits between the decode unit's outputs and the EXU input register.
- Keeps a register scoreboard, an in-flight instruction counter and a mul/div occupancy counter, and decides each cycle whether the decoded instruction may issue.
- Handles the valid/ready handshake toward EXU and produces the IF flush pulse plus a one-cycle shadow bubble on a taken branch.

---
 rtl/core_pkg.sv | 22 ++
 rtl/issue_scoreboard.sv | 49 ++++
 rtl/issue_ctrl.sv | 109 ++++++++++
 tb/tb_issue_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the decode-to-execute issue logic:
// register index width, issue FSM states and hazard-cause codes.
package core_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NREG      = 32;

    typedef enum logic {
        RUN       = 1'b0,
        BR_SHADOW = 1'b1
    } issue_state_e;

    typedef enum logic [2:0] {
        HZ_NONE = 3'd0,
        HZ_RAW  = 3'd1,
        HZ_WAW  = 3'd2,
        HZ_MD   = 3'd3,
        HZ_FULL = 3'd4,
        HZ_EXBP = 3'd5
    } hazard_e;

endpackage

// File: rtl/issue_scoreboard.sv
// Register busy vector: set on issue, cleared on writeback, with a
// same-cycle writeback bypass on all read ports. x0 is never busy.
module issue_scoreboard
    import core_pkg::*;
#(
    parameter int NREG = core_pkg::NREG
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic [REG_IDX_W-1:0] rd,
    input  logic                 set_en,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_rd,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 rd_busy
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    // A register retiring this cycle is already visible as free.
    function automatic logic is_busy(input logic [NREG-1:0]      b,
                                     input logic [REG_IDX_W-1:0] idx,
                                     input logic                 clr,
                                     input logic [REG_IDX_W-1:0] clr_idx);
        return b[idx] && !(clr && (clr_idx == idx));
    endfunction

    assign rs1_busy = is_busy(busy, rs1, clr_en, clr_rd);
    assign rs2_busy = is_busy(busy, rs2, clr_en, clr_rd);
    assign rd_busy  = is_busy(busy, rd,  clr_en, clr_rd);

    // Set after clear so a register re-allocated while retiring stays busy.
    always_comb begin
        busy_next = busy;
        if (clr_en) busy_next[clr_rd] = 1'b0;
        if (set_en) busy_next[rd]     = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy <= '0;
        else      busy <= busy_next;
    end

endmodule

// File: rtl/issue_ctrl.sv
// Issue control between decode and the EXU input register: hazard
// detection, in-flight and mul/div tracking, branch-shadow sequencing.
module issue_ctrl
    import core_pkg::*;
#(
    parameter int NREG         = core_pkg::NREG,
    parameter int MAX_INFLIGHT = 4,
    parameter int MULDIV_LAT   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic                 id_wen,
    input  logic                 id_muldiv,
    input  logic                 id_br_taken,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    input  logic                 wb_valid,
    input  logic                 wb_wen,
    input  logic [REG_IDX_W-1:0] wb_rd,
    output logic                 flush_if,
    output logic                 stall,
    output logic [3:0]           inflight
);

    localparam int MD_W = $clog2(MULDIV_LAT + 1);

    issue_state_e    state, state_next;
    logic [MD_W-1:0] md_cnt;
    logic            fire, wb_clr, set_en;
    logic            rs1_busy, rs2_busy, rd_busy;
    logic            raw_hz, waw_hz, md_hz, full_hz, exbp_hz, hazard;

    assign wb_clr = wb_valid && wb_wen && (wb_rd != '0);
    assign set_en = fire && id_wen && (id_rd != '0);

    issue_scoreboard #(.NREG(NREG)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .rs1      (id_rs1),
        .rs2      (id_rs2),
        .rd       (id_rd),
        .set_en   (set_en),
        .clr_en   (wb_clr),
        .clr_rd   (wb_rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy)
    );

    assign raw_hz  = (id_use_rs1 && rs1_busy) || (id_use_rs2 && rs2_busy);
    assign waw_hz  = id_wen && (id_rd != '0) && rd_busy;
    assign md_hz   = id_muldiv && (md_cnt != '0);
    assign full_hz = (inflight == 4'(MAX_INFLIGHT)) && !wb_valid;
    assign exbp_hz = ex_valid && !ex_ready;
    assign hazard  = raw_hz || waw_hz || md_hz || full_hz || exbp_hz;

    // Gating with rst keeps the combinational outputs low during reset.
    assign id_ready = rst && (state == RUN) && !hazard;
    assign stall    = rst && id_valid && !id_ready;
    assign fire     = id_valid && id_ready;
    assign flush_if = (state == BR_SHADOW);

    always_comb begin
        state_next = state;
        case (state)
            RUN:       if (fire && id_br_taken) state_next = BR_SHADOW;
            BR_SHADOW: state_next = RUN;
            default:   state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_next;
    end

    // A writeback with nothing in flight is dropped rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
        end else begin
            case ({fire, wb_valid && (inflight != '0)})
                2'b10:   inflight <= inflight + 4'd1;
                2'b01:   inflight <= inflight - 4'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   md_cnt <= '0;
        else if (fire && id_muldiv) md_cnt <= MD_W'(MULDIV_LAT);
        else if (md_cnt != '0)      md_cnt <= md_cnt - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          ex_valid <= 1'b0;
        else if (fire)     ex_valid <= 1'b1;
        else if (ex_ready) ex_valid <= 1'b0;
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: hazards, bypass, branch shadow,
// mul/div occupancy, in-flight limit and asynchronous reset.
module tb_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_ready;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2, id_wen, id_muldiv, id_br_taken;
    logic       ex_valid, ex_ready;
    logic       wb_valid, wb_wen;
    logic [4:0] wb_rd;
    logic       flush_if, stall;
    logic [3:0] inflight;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    issue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_wen      (id_wen),
        .id_muldiv   (id_muldiv),
        .id_br_taken (id_br_taken),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .wb_valid    (wb_valid),
        .wb_wen      (wb_wen),
        .wb_rd       (wb_rd),
        .flush_if    (flush_if),
        .stall       (stall),
        .inflight    (inflight)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_wen = 0;
        id_muldiv = 0; id_br_taken = 0;
        wb_valid = 0; wb_wen = 0; wb_rd = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset: all outputs low even with a valid instruction presented
        rst = 0; clr_in(); ex_ready = 1;
        id_valid = 1; id_rs1 = 7; id_use_rs1 = 1;
        #2;
        chk("rst_id_ready", id_ready, 0);
        chk("rst_stall",    stall,    0);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_flush_if", flush_if, 0);
        chk("rst_inflight", inflight, 0);
        tick(); rst = 1; clr_in();

        // Back-to-back independent ALU ops
        tick();
        id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_use_rs1 = 1; id_use_rs2 = 1;
        id_wen = 1; id_rd = 5;
        #1 chk("alu1_ready", id_ready, 1);
        chk("alu1_ex_valid", ex_valid, 0);
        tick(); id_rd = 6;
        #1 chk("alu2_ready", id_ready, 1);
        chk("alu2_ex_valid", ex_valid, 1);
        chk("alu2_inflight", inflight, 1);
        tick(); clr_in(); wb_valid = 1; wb_wen = 1; wb_rd = 5;
        #1 chk("alu_inflight2", inflight, 2);
        tick(); wb_rd = 6;
        tick(); clr_in();
        #1 chk("alu_drain_inflight", inflight, 0);
        chk("alu_drain_ex_valid", ex_valid, 0);

        // RAW stall released by same-cycle writeback bypass
        id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_use_rs1 = 1; id_use_rs2 = 1;
        id_wen = 1; id_rd = 5;
        #1 chk("raw_prod_ready", id_ready, 1);
        tick(); id_rs1 = 5; id_use_rs2 = 0; id_rd = 8;
        #1 chk("raw_stall_a", stall, 1);
        chk("raw_ready_a", id_ready, 0);
        tick();
        #1 chk("raw_stall_b", stall, 1);
        wb_valid = 1; wb_wen = 1; wb_rd = 5;
        #1 chk("raw_bypass_ready", id_ready, 1);
        chk("raw_bypass_stall", stall, 0);
        tick(); clr_in();
        #1 chk("raw_inflight_same", inflight, 1);
        id_valid = 1; id_wen = 1; id_rd = 8;
        #1 chk("waw_stall", stall, 1);
        tick(); clr_in(); wb_valid = 1; wb_wen = 1; wb_rd = 8;
        tick(); clr_in();
        #1 chk("raw_drain_inflight", inflight, 0);

        // Taken branch: flush pulse and one shadow cycle
        id_valid = 1; id_br_taken = 1;
        #1 chk("br_ready_n", id_ready, 1);
        chk("br_flush_n", flush_if, 0);
        tick(); id_br_taken = 0;
        #1 chk("br_flush_n1", flush_if, 1);
        chk("br_ready_n1", id_ready, 0);
        chk("br_stall_n1", stall, 1);
        tick();
        #1 chk("br_flush_n2", flush_if, 0);
        chk("br_ready_n2", id_ready, 1);
        tick(); clr_in(); wb_valid = 1;
        #1 chk("br_inflight", inflight, 2);
        tick(); tick(); clr_in();
        #1 chk("br_drain_inflight", inflight, 0);

        // Back-to-back mul/div: second waits MULDIV_LAT cycles
        id_valid = 1; id_muldiv = 1; id_wen = 1; id_rd = 10; id_rs1 = 1; id_use_rs1 = 1;
        #1 chk("md1_ready", id_ready, 1);
        tick(); id_rd = 11;
        for (int i = 0; i < 8; i++) begin
            #1 chk($sformatf("md2_stall_%0d", i), stall, 1);
            tick();
        end
        #1 chk("md2_ready", id_ready, 1);
        tick(); clr_in(); wb_valid = 1; wb_wen = 1; wb_rd = 10;
        #1 chk("md_inflight", inflight, 2);
        tick(); wb_rd = 11;
        tick(); clr_in();
        #1 chk("md_drain_inflight", inflight, 0);

        // In-flight limit with EXU back-pressure
        id_valid = 1;
        repeat (4) tick();
        ex_ready = 0;
        #1 chk("full_inflight", inflight, 4);
        chk("full_stall", stall, 1);
        tick(); tick();
        #1 chk("hold_inflight", inflight, 4);
        chk("hold_ex_valid", ex_valid, 1);
        chk("hold_stall", stall, 1);
        ex_ready = 1; wb_valid = 1;
        #1 chk("full_wb_ready", id_ready, 1);
        tick(); clr_in();
        #1 chk("full_wb_inflight", inflight, 4);
        wb_valid = 1;
        repeat (4) tick();
        #1 chk("full_drain_inflight", inflight, 0);
        tick(); clr_in();
        #1 chk("underflow_inflight", inflight, 0);

        // Asynchronous reset while stalled on busy x7
        id_valid = 1; id_wen = 1; id_rd = 7;
        #1 chk("x7_prod_ready", id_ready, 1);
        tick(); id_wen = 0; id_rd = 0; id_rs1 = 7; id_use_rs1 = 1;
        #1 chk("x7_stall", stall, 1);
        #1 rst = 0;
        #1 chk("arst_id_ready", id_ready, 0);
        chk("arst_stall",    stall,    0);
        chk("arst_inflight", inflight, 0);
        chk("arst_ex_valid", ex_valid, 0);
        chk("arst_flush_if", flush_if, 0);
        tick(); #1 rst = 1;
        #1 chk("x7_after_rst_ready", id_ready, 1);
        chk("x7_after_rst_stall", stall, 0);
        tick(); clr_in();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
